// File: rtl/gate_sweep_pkg.sv
// Shared types and the golden gate function for the truth-table sweeper.
// golden() takes the live input count so one package serves any N_IN up to 8.
package gate_sweep_pkg;

  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_NAND = 3'd2,
    MODE_NOR  = 3'd3,
    MODE_XOR  = 3'd4,
    MODE_XNOR = 3'd5,
    MODE_MAJ  = 3'd6,
    MODE_RSVD = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MAX_IN = 8;

  // Bits of v at or above n are ignored.
  function automatic logic golden(input logic [MAX_IN-1:0] v, input mode_e m, input int n);
    int   pc;
    logic par;
    logic all1;
    logic any1;
    logic y;
    pc   = 0;
    par  = 1'b0;
    all1 = 1'b1;
    any1 = 1'b0;
    for (int i = 0; i < MAX_IN; i++) begin
      if (i < n) begin
        pc   = pc + int'(v[i]);
        par  = par ^ v[i];
        all1 = all1 & v[i];
        any1 = any1 | v[i];
      end
    end
    case (m)
      MODE_AND:  y = all1;
      MODE_OR:   y = any1;
      MODE_NAND: y = ~all1;
      MODE_NOR:  y = ~any1;
      MODE_XOR:  y = par;
      MODE_XNOR: y = ~par;
      MODE_MAJ:  y = (pc > (n / 2));
      default:   y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_sweep_if.sv
// Control/status bundle between a sweep requester (master) and the sweeper (slave).
interface gate_sweep_if #(parameter int N_IN = 3);

  logic            start;
  logic            abort;
  logic [2:0]      mode;
  logic            dut_y;
  logic [N_IN-1:0] vec;
  logic            vec_valid;
  logic            busy;
  logic            done;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] first_err_vec;
  logic            cfg_err;

  modport master (
    output start, abort, mode, dut_y,
    input  vec, vec_valid, busy, done, err_cnt, first_err_vec, cfg_err
  );

  modport slave (
    input  start, abort, mode, dut_y,
    output vec, vec_valid, busy, done, err_cnt, first_err_vec, cfg_err
  );

endinterface

// File: rtl/gate_ref_model.sv
// Combinational golden output for the current vector and mode.
module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0] vec_i,
  input  mode_e           mode_i,
  output logic            y_exp_o
);

  logic [MAX_IN-1:0] vec_wide;

  always_comb begin
    vec_wide             = '0;
    vec_wide[N_IN-1:0]   = vec_i;
    y_exp_o              = golden(vec_wide, mode_i, N_IN);
  end

endmodule

// File: rtl/gate_sweep_unit.sv
// Exhaustive truth-table sweeper: walks every input vector, holds it HOLD cycles,
// samples the gate under test on the last hold cycle and tallies mismatches.
module gate_sweep_unit
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int HOLD = 5
) (
  input logic          clk,
  input logic          rst_n,
  gate_sweep_if.slave  bus
);

  localparam int               CW        = $clog2(HOLD + 1);
  localparam logic [CW-1:0]    HOLD_LAST = CW'(HOLD - 1);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] first_q, first_d;
  logic            cfg_q, cfg_d;
  logic            y_exp;
  logic            sample;

  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .vec_i   (vec_q),
    .mode_i  (mode_q),
    .y_exp_o (y_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_AND;
      hold_q  <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      cfg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      first_q <= first_d;
      cfg_q   <= cfg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    hold_d  = hold_q;
    vec_d   = vec_q;
    err_d   = err_q;
    first_d = first_q;
    cfg_d   = cfg_q;
    sample  = (hold_q == HOLD_LAST);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (mode_e'(bus.mode) == MODE_RSVD) begin
            cfg_d = 1'b1;
          end else begin
            cfg_d   = 1'b0;
            mode_d  = mode_e'(bus.mode);
            err_d   = '0;
            first_d = '0;
            vec_d   = '0;
            hold_d  = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (sample) begin
          if (bus.dut_y != y_exp) begin
            err_d = err_q + (N_IN + 1)'(1);
            if (err_q == '0) first_d = vec_q;
          end
          hold_d = '0;
          if (vec_q == '1) begin
            state_d = DONE;
            vec_d   = '0;
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end else begin
          hold_d = hold_q + CW'(1);
        end
        // A coincident sample has already been tallied above; abort only cuts the sweep.
        if (bus.abort) begin
          state_d = IDLE;
          vec_d   = '0;
          hold_d  = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.vec           = vec_q;
  assign bus.vec_valid     = (state_q == RUN);
  assign bus.busy          = (state_q == RUN);
  assign bus.done          = (state_q == DONE);
  assign bus.err_cnt       = err_q;
  assign bus.first_err_vec = first_q;
  assign bus.cfg_err       = cfg_q;

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Directed bench for gate_sweep_unit: a 3-input/HOLD=5 instance plus a 4-input/HOLD=2 one.
module tb_gate_sweep_unit;
  import gate_sweep_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   dy_sel;
  logic [3:0] ref_vec;
  logic       ref_y;

  gate_sweep_if #(.N_IN(3)) bus ();
  gate_sweep_if #(.N_IN(4)) bus4 ();

  gate_sweep_unit #(.N_IN(3), .HOLD(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  gate_sweep_unit #(.N_IN(4), .HOLD(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  gate_ref_model #(.N_IN(4)) u_ref4 (.vec_i(ref_vec), .mode_i(MODE_MAJ), .y_exp_o(ref_y));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written gate behaviours fed back as the gate under test.
  always_comb begin
    case (dy_sel)
      0:       bus.dut_y = ~|bus.vec;
      1:       bus.dut_y = (bus.vec == 3'b101) ? 1'b1 : ~|bus.vec;
      3:       bus.dut_y = (bus.vec[0] & bus.vec[1]) | (bus.vec[0] & bus.vec[2]) | (bus.vec[1] & bus.vec[2]);
      default: bus.dut_y = 1'b0;
    endcase
  end
  assign bus4.dut_y = 1'b0;

  task automatic run_sweep(input logic [2:0] m, output int lat);
    lat = -1;
    bus.mode  = m;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 2; k <= 200; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.vec_valid !== 1'b0) begin bad++; $display("FAIL reset_vec_valid: got %b want 0", bus.vec_valid); end
    total++; if (bus.vec !== 3'd0) begin bad++; $display("FAIL reset_vec: got %0d want 0", bus.vec); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.err_cnt !== 4'd0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", bus.err_cnt); end
    total++; if (bus.first_err_vec !== 3'd0) begin bad++; $display("FAIL reset_first: got %0d want 0", bus.first_err_vec); end
    total++; if (bus.cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err: got %b want 0", bus.cfg_err); end
  endtask

  // Clean NOR sweep; also changes mode and pulses start while running (both must be ignored).
  task automatic test_nor_clean;
    int lat;
    lat = -1;
    dy_sel    = 0;
    bus.mode  = 3'd3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.mode  = 3'd0;
    total++; if (bus.busy !== 1'b1 || bus.vec_valid !== 1'b1) begin bad++; $display("FAIL nor_run_entry: busy=%b valid=%b want 1 1", bus.busy, bus.vec_valid); end
    for (int k = 2; k <= 60; k++) begin
      @(posedge clk); #1;
      bus.start = (k == 20);
      if (bus.done) begin
        lat = k;
        break;
      end
      total++; if (int'(bus.vec) !== (k - 1) / 5) begin bad++; $display("FAIL nor_vec_seq at %0d: got %0d want %0d", k, bus.vec, (k - 1) / 5); end
    end
    bus.start = 1'b0;
    total++; if (lat !== 41) begin bad++; $display("FAIL nor_latency: got %0d want 41", lat); end
    total++; if (bus.err_cnt !== 4'd0) begin bad++; $display("FAIL nor_err_cnt: got %0d want 0", bus.err_cnt); end
    total++; if (bus.busy !== 1'b0 || bus.vec_valid !== 1'b0 || bus.vec !== 3'd0) begin bad++; $display("FAIL nor_done_outputs: busy=%b valid=%b vec=%0d want 0 0 0", bus.busy, bus.vec_valid, bus.vec); end
    @(posedge clk); #1;
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL nor_done_pulse_width: got %b want 0", bus.done); end
  endtask

  task automatic test_nor_fault;
    int lat;
    dy_sel = 1;
    run_sweep(3'd3, lat);
    total++; if (lat !== 41) begin bad++; $display("FAIL norf_latency: got %0d want 41", lat); end
    total++; if (bus.err_cnt !== 4'd1) begin bad++; $display("FAIL norf_err_cnt: got %0d want 1", bus.err_cnt); end
    total++; if (bus.first_err_vec !== 3'b101) begin bad++; $display("FAIL norf_first: got %b want 101", bus.first_err_vec); end
  endtask

  // Gate output stuck at 0 under every mode: error count equals the golden ones-count.
  task automatic test_tied0;
    logic [2:0] m_t [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    int         e_t [7] = '{1, 7, 7, 1, 4, 4, 4};
    logic [2:0] f_t [7] = '{3'd7, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd3};
    int lat;
    dy_sel = 2;
    for (int i = 0; i < 7; i++) begin
      run_sweep(m_t[i], lat);
      total++; if (lat !== 41) begin bad++; $display("FAIL tied0_latency mode %0d: got %0d want 41", i, lat); end
      total++; if (int'(bus.err_cnt) !== e_t[i]) begin bad++; $display("FAIL tied0_err_cnt mode %0d: got %0d want %0d", i, bus.err_cnt, e_t[i]); end
      total++; if (bus.first_err_vec !== f_t[i]) begin bad++; $display("FAIL tied0_first mode %0d: got %0d want %0d", i, bus.first_err_vec, f_t[i]); end
    end
  endtask

  task automatic test_maj;
    int lat;
    dy_sel = 3;
    run_sweep(3'd6, lat);
    total++; if (lat !== 41 || bus.err_cnt !== 4'd0) begin bad++; $display("FAIL maj3_loop: lat=%0d err=%0d want 41 0", lat, bus.err_cnt); end
    ref_vec = 4'b0011; #1;
    total++; if (ref_y !== 1'b0) begin bad++; $display("FAIL maj4_tie_0011: got %b want 0", ref_y); end
    ref_vec = 4'b0111; #1;
    total++; if (ref_y !== 1'b1) begin bad++; $display("FAIL maj4_0111: got %b want 1", ref_y); end
    // 4-input instance, gate stuck at 0: popcount>=3 vectors 7,11,13,14,15 mismatch.
    lat = -1;
    bus4.mode  = 3'd6;
    bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    for (int k = 2; k <= 100; k++) begin
      @(posedge clk); #1;
      if (bus4.done) begin
        lat = k;
        break;
      end
    end
    total++; if (lat !== 33) begin bad++; $display("FAIL maj4_latency: got %0d want 33", lat); end
    total++; if (bus4.err_cnt !== 5'd5) begin bad++; $display("FAIL maj4_err_cnt: got %0d want 5", bus4.err_cnt); end
    total++; if (bus4.first_err_vec !== 4'b0111) begin bad++; $display("FAIL maj4_first: got %b want 0111", bus4.first_err_vec); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    int seen_done;
    int lat;
    seen_done = 0;
    dy_sel    = 2;
    bus.mode  = 3'd2;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done++;
      if (k == 11) bus.abort = 1'b1;
    end
    bus.abort = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.vec_valid !== 1'b0) begin bad++; $display("FAIL abort_exit: busy=%b valid=%b want 0 0", bus.busy, bus.vec_valid); end
    total++; if (bus.err_cnt !== 4'd2 || bus.first_err_vec !== 3'd0) begin bad++; $display("FAIL abort_partial: err=%0d first=%0d want 2 0", bus.err_cnt, bus.first_err_vec); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done++;
    end
    total++; if (seen_done !== 0) begin bad++; $display("FAIL abort_no_done: got %0d pulses want 0", seen_done); end
    // Abort on the very cycle of the third sample: that sample still counts.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 15) bus.abort = 1'b1;
    end
    bus.abort = 1'b0;
    total++; if (bus.err_cnt !== 4'd3 || bus.busy !== 1'b0) begin bad++; $display("FAIL abort_on_sample: err=%0d busy=%b want 3 0", bus.err_cnt, bus.busy); end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.err_cnt !== 4'd3) begin bad++; $display("FAIL abort_idle: busy=%b err=%0d want 0 3", bus.busy, bus.err_cnt); end
    run_sweep(3'd2, lat);
    total++; if (lat !== 41 || bus.err_cnt !== 4'd7 || bus.first_err_vec !== 3'd0) begin bad++; $display("FAIL abort_restart: lat=%0d err=%0d first=%0d want 41 7 0", lat, bus.err_cnt, bus.first_err_vec); end
  endtask

  task automatic test_cfg_and_reset;
    int lat;
    bus.mode  = 3'd7;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++; if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL cfg_set: cfg=%b busy=%b want 1 0", bus.cfg_err, bus.busy); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL cfg_sticky: cfg=%b busy=%b want 1 0", bus.cfg_err, bus.busy); end
    dy_sel = 0;
    run_sweep(3'd3, lat);
    total++; if (bus.cfg_err !== 1'b0 || lat !== 41) begin bad++; $display("FAIL cfg_clear: cfg=%b lat=%0d want 0 41", bus.cfg_err, lat); end
    // Reset in the middle of a failing sweep.
    dy_sel    = 2;
    bus.mode  = 3'd2;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    total++; if (bus.busy !== 1'b1 || bus.err_cnt !== 4'd1) begin bad++; $display("FAIL rst_pre: busy=%b err=%0d want 1 1", bus.busy, bus.err_cnt); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.vec_valid !== 1'b0 || bus.vec !== 3'd0) begin bad++; $display("FAIL rst_async_ctl: busy=%b valid=%b vec=%0d want 0 0 0", bus.busy, bus.vec_valid, bus.vec); end
    total++; if (bus.err_cnt !== 4'd0 || bus.first_err_vec !== 3'd0 || bus.done !== 1'b0 || bus.cfg_err !== 1'b0) begin bad++; $display("FAIL rst_async_status: err=%0d first=%0d done=%b cfg=%b want 0 0 0 0", bus.err_cnt, bus.first_err_vec, bus.done, bus.cfg_err); end
    #7;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0 || bus.vec !== 3'd0) begin bad++; $display("FAIL rst_release: busy=%b vec=%0d want 0 0", bus.busy, bus.vec); end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    dy_sel     = 0;
    ref_vec    = 4'd0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.mode   = 3'd0;
    bus4.start = 1'b0;
    bus4.abort = 1'b0;
    bus4.mode  = 3'd0;
    #2;
    test_reset();
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_nor_clean();
    test_nor_fault();
    test_tied0();
    test_maj();
    test_abort();
    test_cfg_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
